// File: rtl/c17_seq_output.sv
// c17 logic cone with a registered 2-entry elastic output buffer and valid/ready on both sides.
// Optional C17_MID_STAGE_EN adds a register stage inside the cone (latency 2 instead of 1).
module c17_seq_output #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             _1,
   input  logic             _2,
   input  logic             _3,
   input  logic             _6,
   input  logic             _7,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             _22,
   output logic             _23,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] xfer_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t     state;
   logic [1:0] head_q;
   logic [1:0] skid_q;
   logic       accept;
   logic       pop;
   logic       push;
   logic [1:0] push_data;
   logic       n8;
   logic       n9;
   logic       n10;

   generate
      if (DEPTH != 2) begin : g_depth_check
         $error("c17_seq_output: DEPTH must be 2");
      end
   endgenerate

   assign n8  = _1 & _3;
   assign n9  = _3 & _6;
   assign n10 = _2 & ~n9;

   assign out_valid = (state != EMPTY);
   assign pop       = out_valid & out_ready;
   assign accept    = in_valid & in_ready;
   assign _22       = head_q[1];
   assign _23       = head_q[0];

`ifdef C17_MID_STAGE_EN
   logic mid_valid;
   logic mid_n8;
   logic mid_n9;
   logic mid_n10;
   logic mid_7;
   logic mid_advance;

   // The mid stage only drains into the buffer when a slot is free this cycle.
   assign mid_advance = mid_valid & ((state != FULL) | pop);
   assign in_ready    = ~mid_valid | mid_advance;
   assign push        = mid_advance;
   assign push_data   = {mid_n8 | mid_n10, mid_n10 | (mid_7 & ~mid_n9)};

   always_ff @(posedge clock) begin
      if (reset) begin
         mid_valid <= 1'b0;
         mid_n8    <= 1'b0;
         mid_n9    <= 1'b0;
         mid_n10   <= 1'b0;
         mid_7     <= 1'b0;
      end else if (in_ready) begin
         mid_valid <= in_valid;
         if (in_valid) begin
            mid_n8  <= n8;
            mid_n9  <= n9;
            mid_n10 <= n10;
            mid_7   <= _7;
         end
      end
   end
`else
   logic n12;

   assign n12       = _7 & ~n9;
   assign in_ready  = (state != FULL);
   assign push      = accept;
   assign push_data = {n8 | n10, n10 | n12};
`endif

   // Head feeds the outputs directly; skid only holds the second entry while FULL.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= EMPTY;
         head_q   <= 2'b00;
         skid_q   <= 2'b00;
         xfer_cnt <= '0;
      end else begin
         if (accept) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
         case (state)
            EMPTY: begin
               if (push) begin
                  head_q <= push_data;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_q <= push_data;
               end else if (push) begin
                  skid_q <= push_data;
                  state  <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_q <= skid_q;
                  if (push) begin
                     skid_q <= push_data;
                  end else begin
                     state <= ONE;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_c17_seq_output.sv
// Self-checking bench for c17_seq_output: vector table, directed corner cases and a
// randomized run against a queue-based reference of the c17 function and buffer.
module tb_c17_seq_output;

   localparam int CNT_W = 16;
`ifdef C17_MID_STAGE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             in_1 = 1'b0;
   logic             in_2 = 1'b0;
   logic             in_3 = 1'b0;
   logic             in_6 = 1'b0;
   logic             in_7 = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             o22;
   logic             o23;
   logic             out_valid;
   logic [CNT_W-1:0] xfer_cnt;

   int checks = 0;
   int errors = 0;
   int cnt_exp = 0;

   typedef struct {
      logic [4:0] vec;
      logic [1:0] exp;
   } vector_t;

   vector_t    table_v[10];
   logic [1:0] sb[$];

   c17_seq_output #(.DEPTH(2), .CNT_W(CNT_W)) dut (
      .clock     (clock),
      .reset     (reset),
      ._1        (in_1),
      ._2        (in_2),
      ._3        (in_3),
      ._6        (in_6),
      ._7        (in_7),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      ._22       (o22),
      ._23       (o23),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clock = ~clock;

   // Reference c17 function; vector bit order is {_1,_2,_3,_6,_7}.
   function automatic logic [1:0] c17_ref(input logic [4:0] v);
      logic a1, a2, a3, a6, a7, r22, r23;
      a1 = v[4]; a2 = v[3]; a3 = v[2]; a6 = v[1]; a7 = v[0];
      r22 = (a1 & a3) | (a2 & ~(a3 & a6));
      r23 = (a2 & ~(a3 & a6)) | (a7 & ~(a3 & a6));
      return {r22, r23};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_vec(input logic [4:0] v);
      {in_1, in_2, in_3, in_6, in_7} = v;
   endtask

   task automatic doReset();
      @(negedge clock);
      reset    = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset   = 1'b0;
      cnt_exp = 0;
   endtask

   task automatic applyStimulus(input vector_t t);
      @(negedge clock);
      drive_vec(t.vec);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (LAT - 1) @(negedge clock);
      cnt_exp++;
      checkOutput("tbl_out_valid", out_valid, 1'b1);
      checkOutput("tbl_result", {o22, o23}, t.exp);
      checkOutput("tbl_xfer_cnt", xfer_cnt, cnt_exp);
   endtask

   initial begin
      int rx, first_rx, last_rx, accepted, popped;
      logic ir_pre, iv, ordy;
      logic [4:0] vec;

      table_v[0] = '{5'b10100, 2'b10};
      table_v[1] = '{5'b01000, 2'b11};
      table_v[2] = '{5'b00001, 2'b01};
      table_v[3] = '{5'b00000, 2'b00};
      table_v[4] = '{5'b01110, 2'b00};
      table_v[5] = '{5'b11111, 2'b10};
      table_v[6] = '{5'b01101, 2'b11};
      table_v[7] = '{5'b00111, 2'b00};
      table_v[8] = '{5'b10011, 2'b01};
      table_v[9] = '{5'b11010, 2'b11};

      $display("[TB] reset and idle");
      doReset();
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_in_ready", in_ready, 1'b1);
      checkOutput("rst_result", {o22, o23}, 2'b00);
      checkOutput("rst_xfer_cnt", xfer_cnt, 0);

      $display("[TB] vector table");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(table_v[i]);
      end

`ifndef C17_MID_STAGE_EN
      $display("[TB] backpressure");
      doReset();
      @(negedge clock);
      drive_vec(5'b01000);
      in_valid = 1'b1;
      @(negedge clock);
      checkOutput("bp_ready_one", in_ready, 1'b1);
      drive_vec(5'b00001);
      @(negedge clock);
      checkOutput("bp_ready_full", in_ready, 1'b0);
      checkOutput("bp_head_valid", out_valid, 1'b1);
      checkOutput("bp_head_first", {o22, o23}, 2'b11);
      drive_vec(5'b10100);
      @(negedge clock);
      checkOutput("bp_held_cnt", xfer_cnt, 2);
      checkOutput("bp_held_ready", in_ready, 1'b0);
      checkOutput("bp_head_stable", {o22, o23}, 2'b11);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      checkOutput("bp_second_valid", out_valid, 1'b1);
      checkOutput("bp_second", {o22, o23}, 2'b01);
      checkOutput("bp_ready_after_pop", in_ready, 1'b1);
      @(negedge clock);
      checkOutput("bp_drained", out_valid, 1'b0);
`endif

      $display("[TB] full sweep");
      doReset();
      sb.delete();
      rx = 0; first_rx = -1; last_rx = -1;
      for (int k = 0; k < 38; k++) begin
         @(negedge clock);
         if (out_valid) begin
            if (sb.size() == 0) begin
               checkOutput("sweep_spurious", 1, 0);
            end else begin
               checkOutput("sweep_result", {o22, o23}, sb.pop_front());
            end
            rx++;
            if (first_rx < 0) first_rx = k;
            last_rx = k;
         end
         if (k < 32) begin
            drive_vec(k[4:0]);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            checkOutput("sweep_in_ready", in_ready, 1'b1);
            sb.push_back(c17_ref(k[4:0]));
         end else begin
            in_valid = 1'b0;
         end
      end
      checkOutput("sweep_count", rx, 32);
      checkOutput("sweep_latency", first_rx, LAT);
      checkOutput("sweep_rate", last_rx - first_rx, 31);
      checkOutput("sweep_xfer_cnt", xfer_cnt, 32);

      $display("[TB] reset while full");
      doReset();
      @(negedge clock);
      drive_vec(5'b01000);
      in_valid = 1'b1;
      @(negedge clock);
      drive_vec(5'b00001);
      @(negedge clock);
      drive_vec(5'b11111);
      @(negedge clock);
      checkOutput("rf_full_ready", in_ready, 1'b0);
      reset     = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);
      checkOutput("rf_out_valid", out_valid, 1'b0);
      checkOutput("rf_in_ready", in_ready, 1'b1);
      checkOutput("rf_xfer_cnt", xfer_cnt, 0);
      checkOutput("rf_result", {o22, o23}, 2'b00);
      reset    = 1'b0;
      in_valid = 1'b0;

      $display("[TB] random traffic");
      doReset();
      sb.delete();
      accepted = 0;
      popped   = 0;
      for (int cyc = 0; cyc < 5000 && accepted < 1000; cyc++) begin
         @(negedge clock);
         ir_pre = in_ready;
         iv   = ($urandom_range(0, 3) != 0);
         ordy = $urandom_range(0, 1) == 1;
         vec  = 5'($urandom_range(0, 31));
         drive_vec(vec);
         in_valid  = iv;
         out_ready = ordy;
         #1;
`ifndef C17_MID_STAGE_EN
         checkOutput("rnd_ready_comb", in_ready, ir_pre);
         checkOutput("rnd_in_ready", in_ready, (accepted - popped) < 2);
         checkOutput("rnd_out_valid", out_valid, (accepted - popped) > 0);
`endif
         if (out_valid) begin
            if (sb.size() == 0) begin
               checkOutput("rnd_spurious", 1, 0);
            end else begin
               checkOutput("rnd_head", {o22, o23}, sb[0]);
               if (ordy) begin
                  void'(sb.pop_front());
                  popped++;
               end
            end
         end
         if (iv && in_ready) begin
            sb.push_back(c17_ref(vec));
            accepted++;
         end
      end
      checkOutput("rnd_accepted", accepted, 1000);
      repeat (8) begin
         @(negedge clock);
         if (out_valid) begin
            if (sb.size() == 0) begin
               checkOutput("drain_spurious", 1, 0);
            end else begin
               checkOutput("drain_head", {o22, o23}, sb.pop_front());
            end
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      checkOutput("rnd_no_loss", sb.size(), 0);
      checkOutput("rnd_xfer_cnt", xfer_cnt, accepted % (1 << CNT_W));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
